// File: rtl/blk_pkg.sv
// Shared types and constants for the block tracker.
// The tracker's optional feature is BLK_TRACKER_LUMA_EN: full 8-bit luma weight instead of a binary vote.
package blk_pkg;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } blk_state_e;

  // Luma level at or above which a pixel votes 1 in binary-weight mode
  localparam logic [7:0] LUMA_THR = 8'd128;

endpackage

// File: rtl/blk_weight.sv
// Combinational per-pixel weight: (R + 2G + B) >> 2, or a binary vote against LUMA_THR.
// Define BLK_TRACKER_LUMA_EN to output the luma value itself.
module blk_weight
  import blk_pkg::*;
(
  input  logic [23:0] data_i,
  output logic [7:0]  wd_o
);

  logic [9:0] w_sum;
  logic [7:0] w_luma;

  assign w_sum  = {2'b00, data_i[23:16]} + {1'b0, data_i[15:8], 1'b0} + {2'b00, data_i[7:0]};
  assign w_luma = 8'(w_sum >> 2);

`ifdef BLK_TRACKER_LUMA_EN
  assign wd_o = w_luma;
`else
  assign wd_o = {7'd0, (w_luma >= LUMA_THR)};
`endif

endmodule

// File: rtl/blk_tracker.sv
// Tracks block column/row position of incoming pixels and flags block boundaries, one-cycle registered.
// Optional feature macro: BLK_TRACKER_LUMA_EN (luma weight on wd_o instead of binary vote). HBLKS/VBLKS must be >= 2.
module blk_tracker
  import blk_pkg::*;
#(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int HBLKW = 192,
  parameter int VBLKH = 108
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     vs_i,
  input  logic                     de_i,
  input  logic [23:0]              data_i,
  output logic [$clog2(HBLKS)-1:0] ht_o,
  output logic [$clog2(VBLKS)-1:0] vt_o,
  output logic                     vs_o,
  output logic                     h_save_o,
  output logic                     v_save_o,
  output logic                     de_o,
  output logic [7:0]               wd_o
);

  // Column/row counters run one past the last block so overrun is a single compare
  localparam int HCW = $clog2(HBLKS + 1);
  localparam int VCW = $clog2(VBLKS + 1);
  localparam int HOW = $clog2(HBLKS);
  localparam int VOW = $clog2(VBLKS);
  localparam int PW  = (HBLKW > 1) ? $clog2(HBLKW) : 1;
  localparam int LW  = (VBLKH > 1) ? $clog2(VBLKH) : 1;

  localparam logic [HCW-1:0] HT_LIM    = HCW'(HBLKS);
  localparam logic [VCW-1:0] VT_LIM    = VCW'(VBLKS);
  localparam logic [HOW-1:0] HT_MAX    = HOW'(HBLKS - 1);
  localparam logic [VOW-1:0] VT_MAX    = VOW'(VBLKS - 1);
  localparam logic [PW-1:0]  PIX_LAST  = PW'(HBLKW - 1);
  localparam logic [LW-1:0]  LINE_LAST = LW'(VBLKH - 1);

  blk_state_e r_state, w_state_next;

  logic           r_vs_d, r_de_d;
  logic [PW-1:0]  r_pix, w_pix_next, w_cur_pix;
  logic [HCW-1:0] r_ht, w_ht_next, w_cur_ht;
  logic [LW-1:0]  r_line, w_line_next, w_cur_line;
  logic [VCW-1:0] r_vt, w_vt_next, w_cur_vt;

  logic [HOW-1:0] r_ht_o, w_ht_o_next;
  logic [VOW-1:0] r_vt_o, w_vt_o_next;
  logic           r_vs_o, w_vs_o_next;
  logic           r_h_save, w_h_save_next;
  logic           r_v_save, w_v_save_next;
  logic           r_de_o, w_de_o_next;
  logic [7:0]     r_wd, w_wd_next;

  logic           w_vs_rise, w_de_fall, w_live, w_valid;
  logic [7:0]     w_weight;

  blk_weight u_weight (
    .data_i (data_i),
    .wd_o   (w_weight)
  );

  assign w_vs_rise = vs_i & ~r_vs_d;
  assign w_de_fall = ~de_i & r_de_d;
  assign w_live    = (r_state == ACTIVE) | w_vs_rise;

  // A vs edge zeroes the counters before the same cycle's pixel is placed
  assign w_cur_pix  = w_vs_rise ? '0 : r_pix;
  assign w_cur_ht   = w_vs_rise ? '0 : r_ht;
  assign w_cur_line = w_vs_rise ? '0 : r_line;
  assign w_cur_vt   = w_vs_rise ? '0 : r_vt;
  assign w_valid    = (w_cur_ht < HT_LIM) && (w_cur_vt < VT_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= WAIT_VS;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pix_next    = w_cur_pix;
    w_ht_next     = w_cur_ht;
    w_line_next   = w_cur_line;
    w_vt_next     = w_cur_vt;
    w_ht_o_next   = (w_cur_ht >= HT_LIM) ? HT_MAX : w_cur_ht[HOW-1:0];
    w_vt_o_next   = (w_cur_vt >= VT_LIM) ? VT_MAX : w_cur_vt[VOW-1:0];
    w_vs_o_next   = 1'b0;
    w_h_save_next = 1'b0;
    w_v_save_next = 1'b0;
    w_de_o_next   = 1'b0;
    w_wd_next     = 8'd0;

    if (w_vs_rise) begin
      w_state_next = ACTIVE;
      w_vs_o_next  = 1'b1;
    end

    if (w_live && de_i) begin
      w_de_o_next   = w_valid;
      w_wd_next     = w_valid ? w_weight : 8'd0;
      w_h_save_next = w_valid && (w_cur_pix == PIX_LAST);
      if (w_cur_pix == PIX_LAST) begin
        w_pix_next = '0;
        if (w_cur_ht < HT_LIM) begin
          w_ht_next = w_cur_ht + 1'b1;
        end
      end else begin
        w_pix_next = w_cur_pix + 1'b1;
      end
    end else if (w_live && w_de_fall && !w_vs_rise) begin
      // End of line: the row counter only moves after v_save_o has shown the finished row
      w_pix_next = '0;
      w_ht_next  = '0;
      if (w_cur_line == LINE_LAST) begin
        w_line_next   = '0;
        w_v_save_next = (w_cur_vt < VT_LIM);
        if (w_cur_vt < VT_LIM) begin
          w_vt_next = w_cur_vt + 1'b1;
        end
      end else begin
        w_line_next = w_cur_line + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs_d   <= 1'b0;
      r_de_d   <= 1'b0;
      r_pix    <= '0;
      r_ht     <= '0;
      r_line   <= '0;
      r_vt     <= '0;
      r_ht_o   <= '0;
      r_vt_o   <= '0;
      r_vs_o   <= 1'b0;
      r_h_save <= 1'b0;
      r_v_save <= 1'b0;
      r_de_o   <= 1'b0;
      r_wd     <= 8'd0;
    end else begin
      r_vs_d   <= vs_i;
      r_de_d   <= de_i;
      r_pix    <= w_pix_next;
      r_ht     <= w_ht_next;
      r_line   <= w_line_next;
      r_vt     <= w_vt_next;
      r_ht_o   <= w_ht_o_next;
      r_vt_o   <= w_vt_o_next;
      r_vs_o   <= w_vs_o_next;
      r_h_save <= w_h_save_next;
      r_v_save <= w_v_save_next;
      r_de_o   <= w_de_o_next;
      r_wd     <= w_wd_next;
    end
  end

  assign ht_o     = r_ht_o;
  assign vt_o     = r_vt_o;
  assign vs_o     = r_vs_o;
  assign h_save_o = r_h_save;
  assign v_save_o = r_v_save;
  assign de_o     = r_de_o;
  assign wd_o     = r_wd;

endmodule
